// File: rtl/mips_ctrl_pkg.sv
// Package: mips_ctrl_pkg
// Shared constants for the multi-cycle MIPS main control FSM. It holds the
// opcode values, the state encodings (also visible on the debug state port),
// the alu_op codes consumed by ula_control, and the alu_src_b and pc_source
// mux select codes.
package mips_ctrl_pkg;

    // instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // alu_op codes for ula_control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // alu_src_b selects
    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pc_source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRExec   = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StAddiEx  = 4'd11,
        StAddiWb  = 4'd12
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Module: mem_wait_timer
// Counts the cycles a memory access has been stalled and flags when the
// stall has reached the timeout limit.
// Ports:
//   clock   in  1      rising-edge clock
//   reset   in  1      synchronous, active-high; clears the count
//   clear   in  1      restart the count (the FSM is changing state)
//   inc     in  1      one more stalled cycle in a wait state
//   expired out 1      count has reached TIMEOUT_CYCLES (never when it is 0)
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    // TIMEOUT_CYCLES == 0 disables the abort entirely; the count may then wrap harmlessly.
    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mips_multicycle_control.sv
// Module: mips_multicycle_control
// Main control FSM of the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath mux selects, write enables and the alu_op code for ula_control,
// stalls on mem_ready and aborts to IDLE when a memory access times out.
// Configuration macro: ADDI_EN (defined: opcode 08 runs ADDI_EX/ADDI_WB;
// undefined: opcode 08 is treated as illegal).
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   opcode[5:0]               instruction[31:26] from the IR
//   mem_ready                 memory completes the access this cycle
//   pc_write, pc_write_cond   PC load enables (unconditional / beq)
//   pc_source[1:0]            PC mux select
//   i_or_d                    memory address select (PC / ALUOut)
//   mem_read, mem_write       memory strobes
//   ir_write                  instruction register load
//   reg_dst, mem_to_reg       register file write address/data selects
//   reg_write                 register file write enable
//   alu_src_a, alu_src_b[1:0] ALU operand selects
//   alu_op[1:0]               to ula_control
//   instr_done                pulse in the last cycle of an instruction
//   illegal_op                pulse in DECODE for an unsupported opcode
//   mem_timeout               pulse on the abort cycle
//   state[3:0]                current state (debug)
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   in_wait;
    logic   expired;
    logic   abort;
    logic   cnt_clear;
    logic   cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_wait   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // Ready wins over an expired count in the same cycle.
    assign abort     = in_wait && !mem_ready && expired;
    // Any state change restarts the count, so entering a wait state starts from 0.
    assign cnt_clear = (state_d != state_q);
    assign cnt_inc   = in_wait && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_mem_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .expired(expired)
    );

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG_B;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                // ALU computes PC+4 while the instruction is read.
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_d     = StIdle;
                end else begin
                    mem_read = 1'b1;
                end
            end
            StDecode: begin
                // Branch target precomputed into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     state_d = StRExec;
                    OP_LW, OP_SW: state_d = StMemAddr;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = StAddiEx;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                i_or_d = 1'b1;
                if (mem_ready) begin
                    mem_read = 1'b1;
                    state_d  = StMemWb;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_d     = StIdle;
                end else begin
                    mem_read = 1'b1;
                end
            end
            StMemWr: begin
                i_or_d = 1'b1;
                if (mem_ready) begin
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_d     = StIdle;
                end else begin
                    mem_write = 1'b1;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
`ifdef ADDI_EN
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench: tb_mips_multicycle_control
// Directed per-cycle vectors; each expected {state, outputs} word is queued
// by the stimulus process and compared by a separate monitor on the falling edge.
module tb_mips_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic       instr_done, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    mips_multicycle_control #(
        .TIMEOUT_CYCLES(15),
        .CNT_W         (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .mem_timeout  (mem_timeout),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output field masks, bit order matches the monitor's packing.
    localparam logic [18:0] PCW     = 19'h40000;
    localparam logic [18:0] PCWC    = 19'h20000;
    localparam logic [18:0] PCS_J   = 19'h10000;
    localparam logic [18:0] PCS_BR  = 19'h08000;
    localparam logic [18:0] IORD    = 19'h04000;
    localparam logic [18:0] MRD     = 19'h02000;
    localparam logic [18:0] MWR     = 19'h01000;
    localparam logic [18:0] IRW     = 19'h00800;
    localparam logic [18:0] RDST    = 19'h00400;
    localparam logic [18:0] M2R     = 19'h00200;
    localparam logic [18:0] RW      = 19'h00100;
    localparam logic [18:0] ASA     = 19'h00080;
    localparam logic [18:0] ASB_SH  = 19'h00060;
    localparam logic [18:0] ASB_IMM = 19'h00040;
    localparam logic [18:0] ASB_4   = 19'h00020;
    localparam logic [18:0] AOP_FN  = 19'h00010;
    localparam logic [18:0] AOP_SUB = 19'h00008;
    localparam logic [18:0] DONE    = 19'h00004;
    localparam logic [18:0] ILL     = 19'h00002;
    localparam logic [18:0] TMO     = 19'h00001;

    localparam logic [18:0] F_WAIT = MRD | ASB_4;
    localparam logic [18:0] F_RDY  = MRD | ASB_4 | IRW | PCW;
    localparam logic [18:0] DEC    = ASB_SH;

    typedef struct {
        int          idx;
        logic [22:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_push = 0;

    // Drive one cycle's inputs and queue the expected outputs for that cycle.
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [18:0] f);
        sb_t e;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        e.idx     = n_push;
        e.exp     = {st, f};
        sb_q.push_back(e);
        n_push++;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_t         e;
            logic [22:0] act;
            e   = sb_q.pop_front();
            act = {state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   instr_done, illegal_op, mem_timeout};
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL vec%0d: state/outputs got %h, required %h", e.idx, act, e.exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Released: IDLE, all outputs zero, then FETCH.
        step(0, 6'h00, 1, 4'd0, 19'h0);

        // R-type: 1,2,7,8
        step(0, 6'h00, 1, 4'd1, F_RDY);
        step(0, 6'h00, 1, 4'd2, DEC);
        step(0, 6'h00, 1, 4'd7, ASA | AOP_FN);
        step(0, 6'h00, 1, 4'd8, RDST | RW | DONE);

        // lw with 3 stall cycles in MEM_RD
        step(0, 6'h23, 1, 4'd1, F_RDY);
        step(0, 6'h23, 1, 4'd2, DEC);
        step(0, 6'h23, 1, 4'd3, ASA | ASB_IMM);
        for (int i = 0; i < 3; i++) step(0, 6'h23, 0, 4'd4, MRD | IORD);
        step(0, 6'h23, 1, 4'd4, MRD | IORD);
        step(0, 6'h23, 1, 4'd5, RW | M2R | DONE);

        // sw with 1 stall cycle; done only in the ready cycle
        step(0, 6'h2B, 1, 4'd1, F_RDY);
        step(0, 6'h2B, 1, 4'd2, DEC);
        step(0, 6'h2B, 1, 4'd3, ASA | ASB_IMM);
        step(0, 6'h2B, 0, 4'd6, MWR | IORD);
        step(0, 6'h2B, 1, 4'd6, MWR | IORD | DONE);

        // beq, j
        step(0, 6'h04, 1, 4'd1, F_RDY);
        step(0, 6'h04, 1, 4'd2, DEC);
        step(0, 6'h04, 1, 4'd9, ASA | AOP_SUB | PCWC | PCS_BR | DONE);
        step(0, 6'h02, 1, 4'd1, F_RDY);
        step(0, 6'h02, 1, 4'd2, DEC);
        step(0, 6'h02, 1, 4'd10, PCW | PCS_J | DONE);

        // Illegal opcode 3F: straight back to FETCH
        step(0, 6'h3F, 1, 4'd1, F_RDY);
        step(0, 6'h3F, 1, 4'd2, DEC | ILL);

        // addi
        step(0, 6'h08, 1, 4'd1, F_RDY);
`ifdef ADDI_EN
        step(0, 6'h08, 1, 4'd2, DEC);
        step(0, 6'h08, 1, 4'd11, ASA | ASB_IMM);
        step(0, 6'h08, 1, 4'd12, RW | DONE);
`else
        step(0, 6'h08, 1, 4'd2, DEC | ILL);
`endif

        // FETCH timeout: 15 stall cycles, abort on the 16th, then IDLE, FETCH
        for (int i = 0; i < 15; i++) step(0, 6'h00, 0, 4'd1, F_WAIT);
        step(0, 6'h00, 0, 4'd1, ASB_4 | TMO);
        step(0, 6'h00, 1, 4'd0, 19'h0);

        // lw: ready arrives exactly at the timeout count, access completes
        step(0, 6'h23, 1, 4'd1, F_RDY);
        step(0, 6'h23, 1, 4'd2, DEC);
        step(0, 6'h23, 1, 4'd3, ASA | ASB_IMM);
        for (int i = 0; i < 15; i++) step(0, 6'h23, 0, 4'd4, MRD | IORD);
        step(0, 6'h23, 1, 4'd4, MRD | IORD);
        step(0, 6'h23, 1, 4'd5, RW | M2R | DONE);

        // sw timeout in MEM_WR: strobe dropped on abort cycle
        step(0, 6'h2B, 1, 4'd1, F_RDY);
        step(0, 6'h2B, 1, 4'd2, DEC);
        step(0, 6'h2B, 1, 4'd3, ASA | ASB_IMM);
        for (int i = 0; i < 15; i++) step(0, 6'h2B, 0, 4'd6, MWR | IORD);
        step(0, 6'h2B, 0, 4'd6, IORD | TMO);
        step(0, 6'h2B, 1, 4'd0, 19'h0);

        // Reset in R_EXEC: outputs still decode R_EXEC, then IDLE with no R_WB
        step(0, 6'h00, 1, 4'd1, F_RDY);
        step(0, 6'h00, 1, 4'd2, DEC);
        step(1, 6'h00, 1, 4'd7, ASA | AOP_FN);
        step(0, 6'h00, 1, 4'd0, 19'h0);
        step(0, 6'h00, 1, 4'd1, F_RDY);

        @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
